muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Multi-cycle RV32M multiply/divide unit: the sequential counterpart to the single-cycle ALU.
//   Sits beside the ALU in the execute stage. It takes the same A/B operands and funct3 encoding.
//   The core issues start and stalls the PC while busy is high. It writes C back when done pulses.
//   Multiply uses an iterative shift-add; divide uses a restoring algorithm, one bit per cycle.
// PARAMETERS
//   XLEN  32  operand/result width; the iteration count equals XLEN
// PORTS
//   clk     in   1     clock, all state updates on rising edge
//   reset   in   1     synchronous, active-high
//   start   in   1     request; sampled only in IDLE
//   A       in   XLEN  rs1 operand (dividend / multiplicand)
//   B       in   XLEN  rs2 operand (divisor / multiplier)
//   funct3  in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   C       out  XLEN  result; held stable from done until the next accepted start
//   busy    out  1     high from the cycle after start is accepted until the cycle done is high (inclusive)
//   done    out  1     single-cycle pulse; C is valid in this cycle
// BEHAVIOUR
//   Reset (sync, active-high): state=IDLE, C=0, busy=0, done=0, counter=0, internal regs cleared.
//     Reset wins over start in the same cycle. Reset mid-operation aborts and discards the result.
//   Accept: in IDLE with start=1, latch A, B and funct3, then set busy=1.
//     start while busy is ignored. Operand changes after acceptance have no effect.
//   Signedness:
//     MULH, DIV, REM: both operands signed.
//     MULHSU: A signed, B unsigned.
//     MUL, MULHU, DIVU, REMU: both operands unsigned.
//     Signed operands are converted to magnitudes on accept. Result sign flags are latched.
//   FSM states: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
//     IDLE->CALC on an accepted normal start; counter loads XLEN.
//     CALC: one iteration per cycle, counter decrements; at counter==1 go to FIXUP.
//       Takes exactly XLEN cycles.
//     FIXUP: apply two's-complement negation per the sign rules, select the result, go to DONE.
//     DONE: done=1, busy=1, C updated; next state IDLE.
//     Normal latency: done asserts XLEN+2 cycles after the start cycle (34 for XLEN=32).
//   Multiply: 2*XLEN-bit product of magnitudes; negate if sign(A)^sign(B) (signed operands only).
//     MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
//   Divide: restoring division of magnitudes.
//     Quotient is negated if the signs differ (DIV only).
//     Remainder takes the sign of the dividend (REM only). Truncation is toward zero.
//   Special cases: IDLE->DONE directly, done asserts 1 cycle after start.
//     B==0: DIV/DIVU give all-ones; REM/REMU give A.
//     DIV/REM with A==0x80000000 and B==all-ones (overflow): DIV gives 0x80000000, REM gives 0.
//   Back-to-back: start may be asserted in the cycle after done (IDLE again).
//     There is no bypass from DONE.
//   Only C, busy and done are visible; the partial product and remainder registers are internal.
// TESTING
//   1. MUL A=7, B=0xFFFFFFFD -> C=0xFFFFFFEB; done exactly 34 cycles after start; busy high 34 cycles.
//   2. High-half multiplies:
//      MULH 0x80000000 * 0x80000000 -> 0x40000000;
//      MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE;
//      MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
//   3. Division:
//      DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF;
//      DIVU 100/7 -> 14; REMU 100/7 -> 2; REM 7/-2 -> 1.
//   4. Special cases (each with done 1 cycle after start):
//      DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5;
//      DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//   5. Handshake:
//      start pulsed with new operands at cycle 10 of a MUL -> ignored, first result unchanged;
//      a second start in the cycle after done -> accepted; C holds the old value until the new done.
//   6. Reset at cycle 15 of a DIV -> next cycle busy=0, done=0, C=0;
//      no done pulse follows; a new op then completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit (shift-add multiply,
//               restoring divide, one bit per cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] C,
    output logic            busy,
    output logic            done
);

    localparam int c_cnt_w = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [2*XLEN-1:0]     r_acc;
    logic [XLEN-1:0]       r_b;
    logic [XLEN-1:0]       r_c;
    logic [2:0]            r_op;
    logic                  r_neg_q;
    logic                  r_neg_r;

    logic                  w_signed_a;
    logic                  w_signed_b;
    logic                  w_sa;
    logic                  w_sb;
    logic [XLEN-1:0]       w_mag_a;
    logic [XLEN-1:0]       w_mag_b;
    logic                  w_div_zero;
    logic                  w_ovf;
    logic                  w_special;
    logic [XLEN-1:0]       w_special_res;
    logic [XLEN:0]         w_mul_sum;
    logic [2*XLEN-1:0]     w_mul_next;
    logic [XLEN:0]         w_rem_sh;
    logic                  w_div_ok;
    logic [XLEN-1:0]       w_sub;
    logic [2*XLEN-1:0]     w_div_next;
    logic [2*XLEN-1:0]     w_prod;
    logic [XLEN-1:0]       w_quot;
    logic [XLEN-1:0]       w_rem;
    logic [XLEN-1:0]       w_fix;

    // Operand decode on the live inputs; only used in the accept cycle
    assign w_signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                        (funct3 == 3'b110);
    assign w_sa       = w_signed_a & A[XLEN-1];
    assign w_sb       = w_signed_b & B[XLEN-1];
    assign w_mag_a    = w_sa ? -A : A;
    assign w_mag_b    = w_sb ? -B : B;

    assign w_div_zero    = funct3[2] && (B == '0);
    assign w_ovf         = funct3[2] && !funct3[0] &&
                           (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
    assign w_special     = w_div_zero || w_ovf;
    assign w_special_res = w_div_zero ? (funct3[1] ? A  : '1)
                                      : (funct3[1] ? '0 : A);

    // Low half of r_acc holds the multiplier (mul) or the dividend/quotient (div)
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_ok   = (w_rem_sh >= {1'b0, r_b});
    assign w_sub      = w_rem_sh[XLEN-1:0] - r_b;
    assign w_div_next = {(w_div_ok ? w_sub : w_rem_sh[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_div_ok};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign w_fix  = r_op[2] ? (r_op[1] ? w_rem : w_quot)
                            : ((r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                                    : w_prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        done   = (r_state == S_DONE);
        case (r_state)
            S_IDLE:  if (start) w_next = w_special ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == c_cnt_w'(1)) w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= funct3;
                        r_b     <= w_mag_b;
                        r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        if (w_special) begin
                            r_c <= w_special_res;
                        end else begin
                            r_cnt <= c_cnt_w'(XLEN);
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[2] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIXUP: r_c <= w_fix;
                default: ;
            endcase
        end
    end

    assign C = r_c;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit (vector table, handshake
//               sequences and randomized ops against an arithmetic model).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [2:0]      funct3;
    logic [XLEN-1:0] C;
    logic            busy;
    logic            done;

    int              n_chk  = 0;
    int              n_pass = 0;
    logic [31:0]     last_c;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .funct3 (funct3),
        .C      (C),
        .busy   (busy),
        .done   (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Plain RV32M arithmetic on 64-bit / signed-int values
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        int          sa;
        int          sb;
        sa = int'(a);
        sb = int'(b);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return XLEN + 2;
    endfunction

    // Called at a negedge while the unit is idle; returns at the negedge after done
    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input int inject);
        int lat      = 0;
        int busy_cnt = 0;
        bit held     = 1'b1;
        bit seen     = 1'b0;
        start  = 1'b1;
        funct3 = f;
        A      = a;
        B      = b;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            start  = 1'b0;
            A      = $urandom;
            B      = $urandom;
            funct3 = 3'($urandom);
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (C !== last_c) held = 1'b0;
                if (inject != 0 && lat == inject) start = 1'b1;
            end
        end
        chk({name, " done_seen"}, 32'(seen), 32'd1);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        chk({name, " C_held_before_done"}, 32'(held), 32'd1);
        chk({name, " result"}, C, exp);
        @(negedge clk);
        chk({name, " idle_after_done"}, {30'b0, busy, done}, 32'd0);
        chk({name, " result_hold"}, C, exp);
        last_c = exp;
    endtask

    initial begin
        int n_done;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          r;

        reset  = 1'b1;
        start  = 1'b0;
        A      = '0;
        B      = '0;
        funct3 = '0;
        last_c = '0;
        repeat (3) @(negedge clk);
        chk("reset C", C, 32'd0);
        chk("reset busy_done", {30'b0, busy, done}, 32'd0);

        // Reset wins over a simultaneous start
        start = 1'b1;
        A     = 32'd9;
        B     = 32'd3;
        @(negedge clk);
        chk("reset_vs_start busy", {31'b0, busy}, 32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("idle busy", {31'b0, busy}, 32'd0);

        tbl.push_back('{"MUL 7*-3",       3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
        tbl.push_back('{"MULH min*min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
        tbl.push_back('{"MULHU ones",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        tbl.push_back('{"MULHSU ones",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
        tbl.push_back('{"DIV -7/2",       3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34});
        tbl.push_back('{"REM -7/2",       3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34});
        tbl.push_back('{"DIVU 100/7",     3'd5, 32'd100,       32'd7,         32'd14,        34});
        tbl.push_back('{"REMU 100/7",     3'd7, 32'd100,       32'd7,         32'd2,         34});
        tbl.push_back('{"REM 7/-2",       3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         34});
        tbl.push_back('{"DIV 5/0",        3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        tbl.push_back('{"REMU 5/0",       3'd7, 32'd5,         32'd0,         32'd5,         1});
        tbl.push_back('{"DIV ovf",        3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        tbl.push_back('{"REM ovf",        3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
        tbl.push_back('{"DIVU min/ones",  3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34});
        tbl.push_back('{"DIVU 0/0",       3'd5, 32'd0,         32'd0,         32'hFFFF_FFFF, 1});
        tbl.push_back('{"MUL ones*ones",  3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         34});

        foreach (tbl[i]) do_op(tbl[i].name, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 0);

        // Junk start mid-operation, then a back-to-back start the cycle after done
        do_op("MUL with junk start", 3'd0, 32'd12345, 32'd678,
              ref_op(3'd0, 32'd12345, 32'd678), 34, 10);
        do_op("DIV back_to_back", 3'd4, 32'hFFFF_FC18, 32'd7,
              ref_op(3'd4, 32'hFFFF_FC18, 32'd7), 34, 0);

        // Reset in the middle of a divide
        start  = 1'b1;
        funct3 = 3'd4;
        A      = 32'd1000;
        B      = 32'd7;
        repeat (15) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("midreset busy_done", {30'b0, busy, done}, 32'd0);
        chk("midreset C", C, 32'd0);
        reset  = 1'b0;
        last_c = '0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midreset no_done", 32'(n_done), 32'd0);
        do_op("DIV after reset", 3'd4, 32'd1000, 32'd7, 32'd142, 34, 0);

        // Randomized ops against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r == 2) b = 32'($urandom_range(1, 15));
            do_op($sformatf("rand%0d f%0d", k, f), f, a, b, ref_op(f, a, b), ref_lat(f, a, b), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
